// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART types, bus addresses and baud divisors
//
// Purpose: receiver state encoding plus the bus address map and baud divisor
//          constants shared across the SPART blocks.
// Ports:   none (package).
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [1:0] ADDR_RXTX   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

  localparam logic [15:0] DIV_4800  = 16'd651;
  localparam logic [15:0] DIV_9600  = 16'd326;
  localparam logic [15:0] DIV_19200 = 16'd163;
  localparam logic [15:0] DIV_38400 = 16'd81;

endpackage

// File: rtl/spart_sync2.sv
// rtl/spart_sync2.sv - two-flop synchronizer with selectable reset value
//
// Purpose: brings an asynchronous level into the clk domain. Also used on the
//          CTS/RTS lines, hence the parameterized reset value.
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous reset, active-low (both flops load RESET_VAL)
//   d      in  1  asynchronous input
//   q      out 1  synchronized output, 2 clk after d
module spart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART serial receiver with oversampled framing and receive buffer
//
// Purpose: oversamples rxd using the baud generator's rx_baud_en, frames
//          characters LSB first (1 start, DATA_BITS data, optional even parity,
//          1 stop) and holds each byte for the bus with RDA / error flags.
// Optional feature: define SPART_RX_PARITY_EN to add an even parity bit and
//          the parity_err output.
// Ports:
//   clk          in  1          system clock
//   rst_n        in  1          asynchronous reset, active-low
//   rxd          in  1          asynchronous serial input, idles high
//   rx_baud_en   in  1          one-clk pulse per 1/OVERSAMPLE bit time
//   rd_en        in  1          bus read of the receive buffer (level)
//   rx_data      out DATA_BITS  receive buffer
//   rda          out 1          receive data available
//   framing_err  out 1          stop bit sampled low
//   overrun_err  out 1          a byte completed while rda was already set
//   parity_err   out 1          even parity mismatch (SPART_RX_PARITY_EN only)
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 rx_baud_en,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
`ifdef SPART_RX_PARITY_EN
  output logic                 overrun_err,
  output logic                 parity_err
`else
  output logic                 overrun_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rxd_s;
  logic                 rxd_q;
`ifdef SPART_RX_PARITY_EN
  logic                 par_bit;
`endif

  spart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick        <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rxd_q       <= 1'b1;
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      rxd_q <= rxd_s;

      // Bus read clears status; a completion later in this block overrides it.
      if (rd_en) begin
        rda         <= 1'b0;
        framing_err <= 1'b0;
        overrun_err <= 1'b0;
`ifdef SPART_RX_PARITY_EN
        parity_err  <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          // Only a 1->0 edge starts a character, so a held-low break starts one at most.
          if (rxd_q && !rxd_s) begin
            state <= START;
            tick  <= '0;
          end
        end

        START: begin
          if (rx_baud_en) begin
            if (tick == TICK_MID) begin
              if (!rxd_s) begin
                state   <= DATA;
                tick    <= '0;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end

        DATA: begin
          if (rx_baud_en) begin
            tick <= tick + 1'b1;
            if (tick == TICK_LAST) begin
              shift <= {rxd_s, shift[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
`ifdef SPART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

`ifdef SPART_RX_PARITY_EN
        PARITY: begin
          if (rx_baud_en) begin
            tick <= tick + 1'b1;
            if (tick == TICK_LAST) begin
              par_bit <= rxd_s;
              state   <= STOP;
            end
          end
        end
`endif

        STOP: begin
          if (rx_baud_en) begin
            tick <= tick + 1'b1;
            if (tick == TICK_LAST) begin
              state <= IDLE;
              if (!rda || rd_en) begin
                rx_data     <= shift;
                rda         <= 1'b1;
                framing_err <= ~rxd_s;
                if (rd_en) begin
                  overrun_err <= 1'b0;
                end
`ifdef SPART_RX_PARITY_EN
                parity_err  <= ^{shift, par_bit};
`endif
              end else begin
                overrun_err <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
